// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Multi-cycle ALU execution unit. It sits behind the ALU control decoder,
// taking the 5-bit ALUCtrl code and the Sign flag. Add/sub/logic/compare
// finish in a single cycle. Shifts run serially, one bit position per cycle.
// The result is handed to the ALUOut stage through a valid/ready handshake.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE, so requests that arrive
// while busy are ignored and must be held by the requester. out_valid is
// high only in DONE. While out_valid is high, out_result, out_zero and
// out_ovf stay constant until out_ready is seen.
//
// Ports:
//   clk, reset          clock (rising edge), async active-high reset
//   in_valid/in_ready   request handshake
//   ALUCtrl, Sign       operation code and signed/unsigned select
//   in_a, in_b          operands; for shifts in_a[SHAMT_W-1:0] is the amount
//   out_valid/out_ready result handshake
//   out_result          registered result
//   out_zero            out_result == 0
//   out_ovf             signed add/sub overflow (only when Sign=1)
//   busy                state != IDLE
//   dbg_state           current FSM state (IDLE=0, SHIFT=1, DONE=2)
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         ALUCtrl,
  input  logic               Sign,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_ovf,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam logic [4:0] OP_AND = 5'b00000;
  localparam logic [4:0] OP_OR  = 5'b00001;
  localparam logic [4:0] OP_ADD = 5'b00010;
  localparam logic [4:0] OP_SUB = 5'b00110;
  localparam logic [4:0] OP_SLT = 5'b00111;
  localparam logic [4:0] OP_NOR = 5'b01000;
  localparam logic [4:0] OP_XOR = 5'b01001;
  localparam logic [4:0] OP_SLL = 5'b01010;
  localparam logic [4:0] OP_SRL = 5'b10000;
  localparam logic [4:0] OP_SRA = 5'b10001;

  localparam logic [1:0] DIR_LEFT = 2'd0;
  localparam logic [1:0] DIR_SRL  = 2'd1;
  localparam logic [1:0] DIR_SRA  = 2'd2;

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]     work_q;
  logic [WIDTH-1:0]     res_q;
  logic                 ovf_q;
  logic [1:0]           dir_q;

  // Single-cycle datapath, evaluated on the live inputs at the accept edge
  logic [WIDTH-1:0]     sum, diff, alu_res;
  logic                 alu_ovf, lt, is_shift;
  logic [1:0]           shift_dir;
  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     step;
  logic                 accept, start_shift;

  assign shamt       = in_a[SHAMT_W-1:0];
  assign sum         = in_a + in_b;
  assign diff        = in_a - in_b;
  assign lt          = Sign ? ($signed(in_a) < $signed(in_b)) : (in_a < in_b);
  assign accept      = (state_q == IDLE) && in_valid;
  assign start_shift = accept && is_shift && (shamt != '0);

  always_comb begin
    alu_res   = sum;
    alu_ovf   = 1'b0;
    is_shift  = 1'b0;
    shift_dir = DIR_LEFT;
    case (ALUCtrl)
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_SUB: begin
        alu_res = diff;
        // Differing operand signs and a result sign that differs from a
        alu_ovf = Sign && (in_a[WIDTH-1] != in_b[WIDTH-1]) &&
                  (diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, lt};
      OP_NOR: alu_res = ~(in_a | in_b);
      OP_XOR: alu_res = in_a ^ in_b;
      // A shift by zero completes immediately with the unshifted value
      OP_SLL: begin alu_res = in_b; is_shift = 1'b1; shift_dir = DIR_LEFT; end
      OP_SRL: begin alu_res = in_b; is_shift = 1'b1; shift_dir = DIR_SRL;  end
      OP_SRA: begin alu_res = in_b; is_shift = 1'b1; shift_dir = DIR_SRA;  end
      default: begin
        // OP_ADD and every undefined code
        alu_res = sum;
        alu_ovf = Sign && (in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                  (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
    endcase
  end

  // One-bit shift step; sra re-copies the MSB, which is always the
  // original sign bit because it is never overwritten.
  always_comb begin
    step = work_q;
    case (dir_q)
      DIR_LEFT: step = {work_q[WIDTH-2:0], 1'b0};
      DIR_SRL:  step = {1'b0, work_q[WIDTH-1:1]};
      DIR_SRA:  step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default:  step = work_q;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (in_valid) state_d = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == CNT_ONE) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    dbg_state = state_q;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      work_q <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      dir_q  <= DIR_LEFT;
    end else begin
      if (start_shift) begin
        work_q <= in_b;
        cnt_q  <= shamt;
        dir_q  <= shift_dir;
      end else if (accept) begin
        res_q <= alu_res;
        ovf_q <= alu_ovf;
      end else if (state_q == SHIFT) begin
        work_q <= step;
        cnt_q  <= cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          res_q <= step;
          ovf_q <= 1'b0;
        end
      end
    end
  end

  assign out_result = res_q;
  assign out_zero   = (res_q == '0);
  assign out_ovf    = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk, reset;
  logic          in_valid, in_ready;
  logic [4:0]    ALUCtrl;
  logic          Sign;
  logic [W-1:0]  in_a, in_b;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic          out_zero, out_ovf, busy;
  logic [1:0]    dbg_state;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [W-1:0]  exp_q[$];

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUCtrl(ALUCtrl), .Sign(Sign), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: straight from the operation definitions
  function automatic void model(input logic [4:0] c, input logic s,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r, output logic o);
    longint x;
    int     sh;
    sh = int'(a[4:0]);
    o  = 1'b0;
    case (c)
      5'b00000: r = a & b;
      5'b00001: r = a | b;
      5'b00110: begin
        x = longint'($signed(a)) - longint'($signed(b));
        r = W'(x);
        o = s && (x > 64'sd2147483647 || x < -64'sd2147483648);
      end
      5'b00111: r = s ? W'($signed(a) < $signed(b)) : W'(a < b);
      5'b01000: r = ~(a | b);
      5'b01001: r = a ^ b;
      5'b01010: r = b << sh;
      5'b10000: r = b >> sh;
      5'b10001: r = W'($signed(b) >>> sh);
      default: begin
        x = longint'($signed(a)) + longint'($signed(b));
        r = W'(x);
        o = s && (x > 64'sd2147483647 || x < -64'sd2147483648);
      end
    endcase
  endfunction

  function automatic bit op_is_shift(input logic [4:0] c);
    return (c == 5'b01010) || (c == 5'b10000) || (c == 5'b10001);
  endfunction

  // Driver: issue one op, check latency/results, optionally stall, then drain.
  task automatic do_op(input logic [4:0] c, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold, input bit keep_ready);
    logic [W-1:0] er, exp_r;
    logic         eo;
    int           lat, exp_lat;
    model(c, s, a, b, er, eo);
    exp_q.push_back(er);
    exp_lat = (op_is_shift(c) && a[4:0] != 5'd0) ? int'(a[4:0]) + 1 : 1;
    @(negedge clk);
    out_ready = keep_ready;
    check("in_ready_idle", W'(in_ready), W'(1));
    in_valid = 1'b1; ALUCtrl = c; Sign = s; in_a = a; in_b = b;
    @(posedge clk); #1;
    // post-accept input changes must have no effect
    in_valid = 1'b0; ALUCtrl = 5'($urandom); Sign = 1'($urandom);
    in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 64) begin
      check("in_ready_shift", W'(in_ready), W'(0));
      in_valid = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", W'(lat), W'(exp_lat));
    check("out_valid", W'(out_valid), W'(1));
    exp_r = exp_q.pop_front();
    check("result", out_result, exp_r);
    check("zero", W'(out_zero), W'(exp_r == '0));
    check("ovf", W'(out_ovf), W'(eo));
    if (!keep_ready) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'($urandom);
        @(posedge clk); #1;
        check("hold_valid", W'(out_valid), W'(1));
        check("hold_result", out_result, exp_r);
        check("hold_in_ready", W'(in_ready), W'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
    end else begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    check("drain_valid", W'(out_valid), W'(0));
    check("drain_in_ready", W'(in_ready), W'(1));
    check("drain_busy", W'(busy), W'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  W'(in_ready),  W'(1));
    check({tag, "_out_valid"}, W'(out_valid), W'(0));
    check({tag, "_result"},    out_result,    W'(0));
    check({tag, "_zero"},      W'(out_zero),  W'(1));
    check({tag, "_ovf"},       W'(out_ovf),   W'(0));
    check({tag, "_busy"},      W'(busy),      W'(0));
  endtask

  logic [4:0] codes[10] = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111,
                            5'b01000, 5'b01001, 5'b01010, 5'b10000, 5'b10001};

  initial begin
    logic [4:0]   c;
    logic [W-1:0] a, b;
    reset = 1'b1; in_valid = 1'b0; ALUCtrl = '0; Sign = 1'b0;
    in_a = '0; in_b = '0; out_ready = 1'b0;
    #12;
    check_reset_outputs("reset");
    @(negedge clk); reset = 1'b0;

    // directed cases
    do_op(5'b00010, 1'b1, 32'h7FFFFFFF, 32'h1, 0, 1'b0);
    do_op(5'b00010, 1'b0, 32'h7FFFFFFF, 32'h1, 0, 1'b1);
    do_op(5'b00110, 1'b1, 32'd5, 32'd5, 0, 1'b0);
    do_op(5'b00110, 1'b1, 32'h80000000, 32'h1, 0, 1'b0);
    do_op(5'b00111, 1'b1, 32'hFFFFFFFF, 32'h1, 0, 1'b0);
    do_op(5'b00111, 1'b0, 32'hFFFFFFFF, 32'h1, 0, 1'b0);
    do_op(5'b10001, 1'b0, 32'h4, 32'h80000010, 0, 1'b0);
    do_op(5'b10000, 1'b0, 32'h4, 32'h80000010, 0, 1'b0);
    do_op(5'b01010, 1'b0, 32'h20, 32'h1234, 0, 1'b0);
    do_op(5'b11111, 1'b0, 32'h2, 32'h3, 0, 1'b0);
    do_op(5'b01001, 1'b0, 32'hA5A5A5A5, 32'h0F0F0F0F, 10, 1'b0);
    do_op(5'b10001, 1'b0, 32'h1F, 32'h80000000, 2, 1'b0);
    do_op(5'b01010, 1'b0, 32'hFFFFFFFF, 32'h1, 0, 1'b1);

    // reset during a long shift aborts it
    @(negedge clk);
    in_valid = 1'b1; ALUCtrl = 5'b01010; Sign = 1'b0; in_a = 32'd31; in_b = 32'h1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 reset = 1'b1;
    #1 check_reset_outputs("midshift_reset");
    @(negedge clk); reset = 1'b0;
    #1 check_reset_outputs("after_reset");
    do_op(5'b00000, 1'b0, 32'hF0F0, 32'hFF00, 0, 1'b0);

    // randomized stimulus
    for (int n = 0; n < 150; n++) begin
      c = ($urandom_range(0, 9) == 0) ? 5'($urandom) : codes[$urandom_range(0, 9)];
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: a = {a[31], 31'($urandom_range(0, 3))};
        default: ;
      endcase
      do_op(c, 1'($urandom), a, b, $urandom_range(0, 3), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Multi-cycle ALU execution unit that consumes the 5-bit ALU control code and Sign flag produced by the ALU control decoder, i.e. the receiving end of the ALUCtrl/Sign interface.
- Performs add/sub/logic/compare in one cycle and shifts serially at one bit per cycle.
- Presents results through a valid/ready handshake to the multi-cycle datapath's ALUOut stage.

Parameters:
- WIDTH, 32, data path width.
- SHAMT_W, 5, shift-amount width; equals log2(WIDTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  unit can accept an operation.
- ALUCtrl  input  5  operation code; encodings are fixed in Behaviour.
- Sign  input  1  1 = signed compare/overflow, 0 = unsigned.
- in_a  input  WIDTH  operand A; for shifts, in_a[SHAMT_W-1:0] is the shift amount.
- in_b  input  WIDTH  operand B; for shifts, the value being shifted.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_result  output  WIDTH  registered result.
- out_zero  output  1  out_result == 0.
- out_ovf  output  1  signed overflow of add/sub; 0 when Sign=0.
- busy  output  1  state != IDLE.

Behaviour:
- Clocking: single clock domain. reset is asynchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_zero=1, out_ovf=0, busy=0, shift counter=0.
- Reset mid-operation aborts the operation immediately. No result is emitted.
- ALUCtrl encodings:
  - 00000 and
  - 00001 or
  - 00010 add
  - 00110 sub (a-b)
  - 00111 slt
  - 01000 nor
  - 01001 xor
  - 01010 sll
  - 10000 srl
  - 10001 sra
  - Any other code executes as add.
- Arithmetic: add/sub wrap modulo 2^WIDTH.
  - out_ovf=1 only when Sign=1 and signed overflow occurs: operands of equal sign for add, differing signs for sub, and the result sign differs from a.
  - out_ovf=0 for all non-add/sub ops.
- slt: result = {0…0, a<b}. Compare is signed if Sign=1, unsigned if Sign=0. Only bit 0 can be set.
- Shift: result is in_b shifted by in_a[SHAMT_W-1:0]. in_a upper bits are ignored.
  - srl fills with 0.
  - sra fills with in_b[WIDTH-1] (the original sign bit).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. When in_valid=1, capture ALUCtrl, Sign, in_a and in_b.
  - IDLE, non-shift op or shamt=0: compute and register the result; next state DONE.
  - IDLE, shift op with shamt>0: load the working register with in_b and the counter with shamt; next state SHIFT.
  - SHIFT: each cycle shift the working register by 1 in the captured direction and decrement the counter. When the counter reaches 0 after the step, register the result and go to DONE.
  - DONE: out_valid=1; out_result, out_zero and out_ovf are held stable. When out_ready=1, go to IDLE.
- Handshake rules:
  - in_ready is low in SHIFT and DONE.
  - in_valid seen outside IDLE is ignored and must be held by the requester.
  - ALUCtrl and operand changes after acceptance have no effect.
- Latency, counted from the accept edge:
  - Non-shift op: out_valid rises 1 cycle later.
  - Shift by n>0: out_valid rises n+1 cycles later.
- Throughput: a new operation can be accepted no earlier than the cycle after the DONE→IDLE transition. No overlap between operations.
- out_zero is computed from the registered result. It is meaningful only while out_valid=1.
- Boundary conditions:
  - out_ready may be held high permanently.
  - out_ready held low keeps DONE indefinitely with outputs stable.
  - Shift by WIDTH-1 is the maximum and takes WIDTH cycles.

Test Plan:
- add, Sign=1, a=0x7FFFFFFF, b=1 → out_result=0x80000000, out_ovf=1, out_zero=0, out_valid 1 cycle after accept. Same operands with Sign=0 → out_ovf=0.
- sub, a=5, b=5 → out_result=0, out_zero=1. slt with a=0xFFFFFFFF, b=1: Sign=1 → 1; Sign=0 → 0.
- sra, a=4, b=0x80000010 → out_result=0xF8000001, out_valid exactly 5 cycles after accept, in_ready=0 throughout. srl with the same operands → 0x08000001.
- sll, a=0x20 (shamt field 0), b=0x1234 → out_result=0x1234, 1-cycle latency. Undefined code 11111 with a=2, b=3 → out_result=5.
- out_ready held low for 10 cycles in DONE → out_valid and out_result stable and in_ready=0. in_valid pulses during SHIFT/DONE are not accepted.
- Assert reset during SHIFT of an sll by 31 → outputs at reset values in the same cycle. The next accepted op (and 0xF0F0, 0xFF00) returns 0xF000 normally.
